clock_time_ctrl: RTL
====================

Name: clock_time_ctrl

Overview:
Time-keeping and set-mode controller for the digital clock. It holds the hh:mm:ss value and advances it once per second in run mode. It also runs the button-driven set mode: enter/exit, digit cursor, digit increment. It drives the hours/minutes/seconds, pos and set_mod inputs of the display block directly.

Parameters:
CLK_HZ, 50000000, input clock frequency; the 1 Hz tick fires every CLK_HZ cycles (tests use small values, e.g. 4)

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
btn_mode  input  1  debounced level; rising edge toggles RUN/SET
btn_next  input  1  debounced level; rising edge advances cursor (SET only)
btn_inc  input  1  debounced level; rising edge increments selected digit (SET only)
hours  output  6  0..23, binary
minutes  output  6  0..59, binary
seconds  output  6  0..59, binary
pos  output  3  cursor digit: 0 sec_lo, 1 sec_hi, 2 min_lo, 3 min_hi, 4 hr_lo, 5 hr_hi
set_mod  output  1  1 while in SET

Behaviour:
- Reset (async, rst_n low): all digits 0 (00:00:00), pos=0, set_mod=0, state RUN, tick counter 0, synchronizers cleared. Outputs reflect reset immediately.
- Time state: six BCD digit registers. Outputs are combinational from them: hours=hr_hi*10+hr_lo, etc. No input-to-output combinational path.
- Buttons: each goes through a 2-FF synchronizer plus rising-edge detect, giving a 1-cycle pulse. An action takes effect at the 3rd rising clk edge that samples the level high. A held button acts once.
- States: RUN, SET. set_mod = (state==SET).
- RUN: tick counter counts 0..CLK_HZ-1.
  - At CLK_HZ-1 the counter wraps to 0 and the time advances 1 s in the same edge.
  - Full carry chain applies: 23:59:59 -> 00:00:00.
- RUN + mode pulse: go to SET, pos<=0, counter<=0, no tick that cycle.
- SET:
  - Counter held at 0; time changes only via inc.
  - next pulse: pos 0->1->...->5->0.
  - mode pulse: go to RUN, pos<=0, counter restarts from 0. The first tick comes CLK_HZ cycles later.
- Increment rules (selected digit only, no carry into neighbours):
  - sec_lo/min_lo: 0..9 wrap.
  - sec_hi/min_hi: 0..5 wrap.
  - hr_hi: 0->1->2->0. If the new value is 2 and hr_lo>3, hr_lo<=3.
  - hr_lo: 0..9 wrap if hr_hi<2; 0..3 wrap if hr_hi==2.
- Simultaneous pulses:
  - mode has priority; next/inc pulses in that cycle are dropped.
  - inc+next together: inc applies to the current pos, then pos advances.
- Pulses of next/inc in RUN are ignored.
- Invariant: hours<=23, minutes<=59, seconds<=59 at every cycle.

Decomposition:
- Shared package clock_pkg:
  - state enum {RUN, SET}
  - POS_SEC_LO..POS_HR_HI constants (0..5)
  - POS_MAX=5
  - digit limit constants (9, 5, 2, 3)
- Sub-module btn_edge (2-FF sync + rising-edge pulse, async active-low reset), instantiated three times.

Test Plan:
- Reset: hold rst_n=0 mid-run -> outputs immediately 0/0/0, pos=0, set_mod=0. Release -> first seconds increment exactly CLK_HZ cycles later.
- Run carry (CLK_HZ=4): after 240 cycles from reset -> minutes=1, seconds=0. Preset 23:59:58 via SET, return to RUN, 8 cycles -> 00:00:00.
- Set entry/cursor: mode pulse -> set_mod=1, pos=0. next x7 -> pos=1. Three cycles held high on btn_next gives a single advance.
- Digit increment: pos=0, inc x12 -> seconds=2 (wrap at 9). pos=1, inc x7 -> sec_hi=1, seconds=12. Minutes untouched. Counter frozen: 1000 idle cycles leave time unchanged.
- Hour clamp: hours=19, pos=5, inc -> hours=23. inc again -> hours=03. pos=4 with hours=23, inc -> 20.
- Simultaneous: mode+inc same cycle in SET -> RUN, time unchanged. inc+next together at pos=2 -> min_lo+1, pos=3.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared types and constants for the digital-clock time/set controller.
// Provides the RUN/SET state enum, cursor positions, digit limits, the
// packed hh:mm:ss BCD payload and a BCD-to-binary helper.
package clock_pkg;

    typedef enum logic {
        RUN = 1'b0,
        SET = 1'b1
    } state_t;

    localparam int unsigned POS_W = 3;
    localparam int unsigned DIG_W = 4;
    localparam int unsigned BIN_W = 6;

    localparam logic [POS_W-1:0] POS_SEC_LO = 3'd0;
    localparam logic [POS_W-1:0] POS_SEC_HI = 3'd1;
    localparam logic [POS_W-1:0] POS_MIN_LO = 3'd2;
    localparam logic [POS_W-1:0] POS_MIN_HI = 3'd3;
    localparam logic [POS_W-1:0] POS_HR_LO  = 3'd4;
    localparam logic [POS_W-1:0] POS_HR_HI  = 3'd5;
    localparam logic [POS_W-1:0] POS_MAX    = 3'd5;

    localparam logic [DIG_W-1:0] LIM_LO       = 4'd9;  // any units digit
    localparam logic [DIG_W-1:0] LIM_HI       = 4'd5;  // tens of sec/min
    localparam logic [DIG_W-1:0] LIM_HR_HI    = 4'd2;  // tens of hours
    localparam logic [DIG_W-1:0] LIM_HR_LO_20 = 4'd3;  // hour units when tens==2

    typedef struct packed {
        logic [DIG_W-1:0] hr_hi;
        logic [DIG_W-1:0] hr_lo;
        logic [DIG_W-1:0] min_hi;
        logic [DIG_W-1:0] min_lo;
        logic [DIG_W-1:0] sec_hi;
        logic [DIG_W-1:0] sec_lo;
    } bcd_time_t;

    function automatic logic [BIN_W-1:0] bcd_to_bin(input logic [DIG_W-1:0] hi,
                                                    input logic [DIG_W-1:0] lo);
        return BIN_W'(hi) * BIN_W'(10) + BIN_W'(lo);
    endfunction

endpackage

// File: rtl/btn_edge.sv
// Two-flop synchronizer plus rising-edge detector for a debounced button.
// Ports: clk, rst_n (async active-low), btn (async level),
//        pulse_c (one-cycle pulse, combinational from flops only).
module btn_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic pulse_c
);

    // sync_q[0..1] synchronize, sync_q[2] holds the previous synchronized level
    logic [2:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 3'b000;
        end else begin
            sync_q <= {sync_q[1:0], btn};
        end
    end

    assign pulse_c = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/clock_time_ctrl.sv
// Time-keeping and set-mode controller: holds hh:mm:ss as BCD digits,
// ticks once per CLK_HZ cycles in RUN, and edits digits from buttons in SET.
// Ports: clk, rst_n (async active-low); btn_mode/btn_next/btn_inc debounced
//        levels; hours/minutes/seconds binary time; pos cursor digit;
//        set_mod high while in SET.
module clock_time_ctrl
    import clock_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_mode,
    input  logic             btn_next,
    input  logic             btn_inc,
    output logic [BIN_W-1:0] hours,
    output logic [BIN_W-1:0] minutes,
    output logic [BIN_W-1:0] seconds,
    output logic [POS_W-1:0] pos,
    output logic             set_mod
);

    localparam int unsigned CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_HZ - 1);

    logic mode_p_c, next_p_c, inc_p_c;

    btn_edge u_mode (.clk(clk), .rst_n(rst_n), .btn(btn_mode), .pulse_c(mode_p_c));
    btn_edge u_next (.clk(clk), .rst_n(rst_n), .btn(btn_next), .pulse_c(next_p_c));
    btn_edge u_inc  (.clk(clk), .rst_n(rst_n), .btn(btn_inc),  .pulse_c(inc_p_c));

    state_t           state;
    bcd_time_t        tm;
    logic [CNT_W-1:0] cnt;
    bcd_time_t        tm_adv_c;
    bcd_time_t        tm_inc_c;

    // One-second advance with the full carry chain, 23:59:59 -> 00:00:00
    always_comb begin
        tm_adv_c = tm;
        if (tm.sec_lo != LIM_LO) begin
            tm_adv_c.sec_lo = tm.sec_lo + 4'd1;
        end else begin
            tm_adv_c.sec_lo = 4'd0;
            if (tm.sec_hi != LIM_HI) begin
                tm_adv_c.sec_hi = tm.sec_hi + 4'd1;
            end else begin
                tm_adv_c.sec_hi = 4'd0;
                if (tm.min_lo != LIM_LO) begin
                    tm_adv_c.min_lo = tm.min_lo + 4'd1;
                end else begin
                    tm_adv_c.min_lo = 4'd0;
                    if (tm.min_hi != LIM_HI) begin
                        tm_adv_c.min_hi = tm.min_hi + 4'd1;
                    end else begin
                        tm_adv_c.min_hi = 4'd0;
                        if (tm.hr_hi == LIM_HR_HI && tm.hr_lo == LIM_HR_LO_20) begin
                            tm_adv_c.hr_hi = 4'd0;
                            tm_adv_c.hr_lo = 4'd0;
                        end else if (tm.hr_lo == LIM_LO) begin
                            tm_adv_c.hr_lo = 4'd0;
                            tm_adv_c.hr_hi = tm.hr_hi + 4'd1;
                        end else begin
                            tm_adv_c.hr_lo = tm.hr_lo + 4'd1;
                        end
                    end
                end
            end
        end
    end

    // Cursor-digit increment, wrapping within the digit; hour pair kept <= 23
    always_comb begin
        tm_inc_c = tm;
        case (pos)
            POS_SEC_LO: tm_inc_c.sec_lo = (tm.sec_lo >= LIM_LO) ? 4'd0 : tm.sec_lo + 4'd1;
            POS_SEC_HI: tm_inc_c.sec_hi = (tm.sec_hi >= LIM_HI) ? 4'd0 : tm.sec_hi + 4'd1;
            POS_MIN_LO: tm_inc_c.min_lo = (tm.min_lo >= LIM_LO) ? 4'd0 : tm.min_lo + 4'd1;
            POS_MIN_HI: tm_inc_c.min_hi = (tm.min_hi >= LIM_HI) ? 4'd0 : tm.min_hi + 4'd1;
            POS_HR_LO: begin
                if (tm.hr_hi == LIM_HR_HI) begin
                    tm_inc_c.hr_lo = (tm.hr_lo >= LIM_HR_LO_20) ? 4'd0 : tm.hr_lo + 4'd1;
                end else begin
                    tm_inc_c.hr_lo = (tm.hr_lo >= LIM_LO) ? 4'd0 : tm.hr_lo + 4'd1;
                end
            end
            POS_HR_HI: begin
                tm_inc_c.hr_hi = (tm.hr_hi >= LIM_HR_HI) ? 4'd0 : tm.hr_hi + 4'd1;
                if (tm_inc_c.hr_hi == LIM_HR_HI && tm.hr_lo > LIM_HR_LO_20) begin
                    tm_inc_c.hr_lo = LIM_HR_LO_20;
                end
            end
            default: tm_inc_c = tm;
        endcase
    end

    // Mode FSM, tick counter, time and cursor registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            tm    <= '0;
            cnt   <= '0;
            pos   <= POS_SEC_LO;
        end else begin
            case (state)
                RUN: begin
                    if (mode_p_c) begin
                        state <= SET;
                        pos   <= POS_SEC_LO;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        tm  <= tm_adv_c;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                SET: begin
                    cnt <= '0;
                    if (mode_p_c) begin
                        state <= RUN;
                        pos   <= POS_SEC_LO;
                    end else begin
                        if (inc_p_c) begin
                            tm <= tm_inc_c;
                        end
                        if (next_p_c) begin
                            pos <= (pos == POS_MAX) ? POS_SEC_LO : pos + 3'd1;
                        end
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    assign hours   = bcd_to_bin(tm.hr_hi, tm.hr_lo);
    assign minutes = bcd_to_bin(tm.min_hi, tm.min_lo);
    assign seconds = bcd_to_bin(tm.sec_hi, tm.sec_lo);
    assign set_mod = (state == SET);

endmodule
